alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_shifter.sv | 26 ++
 rtl/alu.sv | 80 ++++++++
 tb/tb_alu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default data width, opcode type and shifter modes.
// Used by the RTL and by the testbench so both agree on the opcode map.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef enum logic [4:0] {
        OP_ADD   = 5'h00,
        OP_SUB   = 5'h01,
        OP_AND   = 5'h02,
        OP_OR    = 5'h03,
        OP_XOR   = 5'h04,
        OP_NOT   = 5'h05,
        OP_NEG   = 5'h06,
        OP_SHL   = 5'h07,
        OP_SHR   = 5'h08,
        OP_SRA   = 5'h09,
        OP_SLT   = 5'h0A,
        OP_SLTU  = 5'h0B,
        OP_MUL   = 5'h0C,
        OP_PASSX = 5'h0D,
        OP_PASSY = 5'h0E
    } alu_op_e;

    // Shifter mode encoding; the remaining code passes the value through.
    localparam logic [1:0] SH_LEFT  = 2'd0;
    localparam logic [1:0] SH_RIGHT = 2'd1;
    localparam logic [1:0] SH_ARITH = 2'd2;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter: logical left, logical right, arithmetic right.
// Mode codes come from alu_pkg; an unused mode passes the value through.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   shifted
);

    // Select the shift flavour; arithmetic right replicates the sign bit.
    always_comb begin
        shifted = value;
        case (mode)
            SH_LEFT:  shifted = value << amount;
            SH_RIGHT: shifted = value >> amount;
            SH_ARITH: shifted = WIDTH'($signed(value) >>> amount);
            default:  shifted = value;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Single-cycle-latency ALU with a registered result.
// Optional multiplier enabled by defining macro ALU_MUL_EN; without it
// opcode MUL behaves like an unused code and returns zero.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    output logic [WIDTH-1:0] z,
    input  logic [4:0]       ALUop,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             clk,
    input  logic             reset
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] z_d;
    logic [WIDTH-1:0] z_q;
    logic [WIDTH-1:0] shift_out_s;
    logic [1:0]       shift_mode_s;

    // Map the shift opcodes onto the shifter mode; other opcodes ignore its output.
    always_comb begin
        shift_mode_s = SH_LEFT;
        case (ALUop)
            OP_SHR:  shift_mode_s = SH_RIGHT;
            OP_SRA:  shift_mode_s = SH_ARITH;
            default: shift_mode_s = SH_LEFT;
        endcase
    end

    alu_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .value   (X),
        .amount  (Y[SHAMT_W-1:0]),
        .mode    (shift_mode_s),
        .shifted (shift_out_s)
    );

    // Result selection: one case on the opcode, wrapping arithmetic, zero for unused codes.
    always_comb begin
        z_d = {WIDTH{1'b0}};
        case (ALUop)
            OP_ADD:   z_d = X + Y;
            OP_SUB:   z_d = X - Y;
            OP_AND:   z_d = X & Y;
            OP_OR:    z_d = X | Y;
            OP_XOR:   z_d = X ^ Y;
            OP_NOT:   z_d = ~X;
            OP_NEG:   z_d = {WIDTH{1'b0}} - X;
            OP_SHL:   z_d = shift_out_s;
            OP_SHR:   z_d = shift_out_s;
            OP_SRA:   z_d = shift_out_s;
            OP_SLT:   z_d = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
            OP_SLTU:  z_d = {{(WIDTH-1){1'b0}}, (X < Y)};
`ifdef ALU_MUL_EN
            OP_MUL:   z_d = X * Y;
`endif
            OP_PASSX: z_d = X;
            OP_PASSY: z_d = Y;
            default:  z_d = {WIDTH{1'b0}};
        endcase
    end

    // Result register; reset clears it and discards whatever was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q <= {WIDTH{1'b0}};
        end else begin
            z_q <= z_d;
        end
    end

    assign z = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH = 16).
module tb_alu;
    import alu_pkg::*;

    localparam int W = ALU_WIDTH;

    logic [W-1:0] z;
    logic [4:0]   ALUop;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         clk;
    logic         reset;

    int n_cmp = 0;
    int n_err = 0;

    alu #(.WIDTH(W)) dut (
        .z     (z),
        .ALUop (ALUop),
        .X     (X),
        .Y     (Y),
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: built from different primitives than the RTL.
    function automatic logic [W-1:0] ref_alu(input logic [4:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [3:0]   s;
        logic [W-1:0] r;
        logic [W-1:0] ones;
        s    = b[3:0];
        ones = 16'hFFFF;
        r    = 16'h0000;
        case (op)
            5'h00: r = 16'((32'(a) + 32'(b)) % 32'h10000);
            5'h01: r = 16'((32'(a) + 32'h10000 - 32'(b)) % 32'h10000);
            5'h02: r = a & b;
            5'h03: r = a | b;
            5'h04: r = a ^ b;
            5'h05: r = a ^ 16'hFFFF;
            5'h06: r = (a ^ 16'hFFFF) + 16'h0001;
            5'h07: r = a << s;
            5'h08: r = a >> s;
            5'h09: r = (a >> s) | (a[15] ? ~(ones >> s) : 16'h0000);
            5'h0A: r = ((a ^ 16'h8000) < (b ^ 16'h8000)) ? 16'h0001 : 16'h0000;
            5'h0B: r = (a < b) ? 16'h0001 : 16'h0000;
`ifdef ALU_MUL_EN
            5'h0C: r = 16'((32'(a) * 32'(b)) % 32'h10000);
`endif
            5'h0D: r = a;
            5'h0E: r = b;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUop = op;
        X     = a;
        Y     = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(OP_ADD, 16'd5, 16'd7);
        n_cmp++;
        if (z !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_hold: z=%h expected %h", z, 16'h0000);
        end
        reset = 1'b0;
        drive(OP_ADD, 16'd5, 16'd7);
        n_cmp++;
        if (z !== 16'd12) begin
            n_err++;
            $display("FAIL reset_release: z=%h expected %h", z, 16'd12);
        end
    endtask

    task automatic test_midstream_reset();
        drive(OP_ADD, 16'd1, 16'd2);
        n_cmp++;
        if (z !== 16'd3) begin
            n_err++;
            $display("FAIL mid_pre: z=%h expected %h", z, 16'd3);
        end
        reset = 1'b1;
        drive(OP_PASSY, 16'h1234, 16'hBEEF);
        n_cmp++;
        if (z !== 16'h0000) begin
            n_err++;
            $display("FAIL mid_reset: z=%h expected %h", z, 16'h0000);
        end
        reset = 1'b0;
        drive(OP_XOR, 16'hA5A5, 16'h0F0F);
        n_cmp++;
        if (z !== 16'hAAAA) begin
            n_err++;
            $display("FAIL mid_first: z=%h expected %h", z, 16'hAAAA);
        end
    endtask

    task automatic test_arith();
        drive(OP_ADD, 16'hFFFF, 16'h0001);
        n_cmp++;
        if (z !== 16'h0000) begin n_err++; $display("FAIL add_wrap: z=%h expected %h", z, 16'h0000); end
        drive(OP_SUB, 16'h0000, 16'h0001);
        n_cmp++;
        if (z !== 16'hFFFF) begin n_err++; $display("FAIL sub_wrap: z=%h expected %h", z, 16'hFFFF); end
        drive(OP_NEG, 16'h0001, 16'h0000);
        n_cmp++;
        if (z !== 16'hFFFF) begin n_err++; $display("FAIL neg: z=%h expected %h", z, 16'hFFFF); end
        drive(OP_NOT, 16'h00FF, 16'h0000);
        n_cmp++;
        if (z !== 16'hFF00) begin n_err++; $display("FAIL not: z=%h expected %h", z, 16'hFF00); end
    endtask

    task automatic test_logic_compare();
        drive(OP_AND, 16'hF0F0, 16'h0FF0);
        n_cmp++;
        if (z !== 16'h00F0) begin n_err++; $display("FAIL and: z=%h expected %h", z, 16'h00F0); end
        drive(OP_OR, 16'hF000, 16'h000F);
        n_cmp++;
        if (z !== 16'hF00F) begin n_err++; $display("FAIL or: z=%h expected %h", z, 16'hF00F); end
        drive(OP_SLT, 16'h8000, 16'h0001);
        n_cmp++;
        if (z !== 16'h0001) begin n_err++; $display("FAIL slt_neg: z=%h expected %h", z, 16'h0001); end
        drive(OP_SLTU, 16'h8000, 16'h0001);
        n_cmp++;
        if (z !== 16'h0000) begin n_err++; $display("FAIL sltu: z=%h expected %h", z, 16'h0000); end
        drive(OP_SLT, 16'h8000, 16'h7FFF);
        n_cmp++;
        if (z !== 16'h0001) begin n_err++; $display("FAIL slt_ovf: z=%h expected %h", z, 16'h0001); end
        drive(OP_SLT, 16'h7FFF, 16'h8000);
        n_cmp++;
        if (z !== 16'h0000) begin n_err++; $display("FAIL slt_rev: z=%h expected %h", z, 16'h0000); end
    endtask

    task automatic test_shift();
        drive(OP_SHL, 16'h0001, 16'h0013);
        n_cmp++;
        if (z !== 16'h0008) begin n_err++; $display("FAIL shl_mask: z=%h expected %h", z, 16'h0008); end
        drive(OP_SRA, 16'h8000, 16'h000F);
        n_cmp++;
        if (z !== 16'hFFFF) begin n_err++; $display("FAIL sra_max: z=%h expected %h", z, 16'hFFFF); end
        drive(OP_SHR, 16'h8000, 16'h000F);
        n_cmp++;
        if (z !== 16'h0001) begin n_err++; $display("FAIL shr_max: z=%h expected %h", z, 16'h0001); end
        drive(OP_SRA, 16'h8421, 16'hFFF0);
        n_cmp++;
        if (z !== 16'h8421) begin n_err++; $display("FAIL sra_zero: z=%h expected %h", z, 16'h8421); end
        drive(OP_SRA, 16'h7000, 16'h0004);
        n_cmp++;
        if (z !== 16'h0700) begin n_err++; $display("FAIL sra_pos: z=%h expected %h", z, 16'h0700); end
    endtask

    task automatic test_config();
        logic [W-1:0] exp_mul;
`ifdef ALU_MUL_EN
        exp_mul = 16'h5F90;
`else
        exp_mul = 16'h0000;
`endif
        drive(OP_MUL, 16'd300, 16'd300);
        n_cmp++;
        if (z !== exp_mul) begin n_err++; $display("FAIL mul: z=%h expected %h", z, exp_mul); end
        drive(5'h1F, 16'h1234, 16'h5678);
        n_cmp++;
        if (z !== 16'h0000) begin n_err++; $display("FAIL unused_1f: z=%h expected %h", z, 16'h0000); end
        drive(5'h0F, 16'hFFFF, 16'hFFFF);
        n_cmp++;
        if (z !== 16'h0000) begin n_err++; $display("FAIL unused_0f: z=%h expected %h", z, 16'h0000); end
        drive(OP_PASSX, 16'hCAFE, 16'h1111);
        n_cmp++;
        if (z !== 16'hCAFE) begin n_err++; $display("FAIL passx: z=%h expected %h", z, 16'hCAFE); end
        drive(OP_PASSY, 16'hCAFE, 16'h1111);
        n_cmp++;
        if (z !== 16'h1111) begin n_err++; $display("FAIL passy: z=%h expected %h", z, 16'h1111); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_z;
        for (int i = 0; i < 20; i++) begin
            op    = 5'($urandom_range(0, 15));
            a     = 16'($urandom);
            b     = 16'($urandom);
            exp_z = ref_alu(op, a, b);
            drive(op, a, b);
            n_cmp++;
            if (z !== exp_z) begin
                n_err++;
                $display("FAIL b2b[%0d] op=%h x=%h y=%h: z=%h expected %h", i, op, a, b, z, exp_z);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        ALUop = 5'h00;
        X     = 16'h0000;
        Y     = 16'h0000;
        test_reset();
        test_midstream_reset();
        test_arith();
        test_logic_compare();
        test_shift();
        test_config();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
